mul_seq_ctrl: RTL and testbench

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

---
 rtl/mul_seq_ctrl_if.sv | 33 +++
 rtl/mul_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_mul_seq_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_seq_ctrl_if.sv
// mul_seq_ctrl_if: bundles the request/response and adder-facing signals of
// the sequential multiply controller.
//   start/a/b/abort : operation request from the master
//   adder_out       : accumulator value returned by the external adder
//   ready/err       : handshake status back to the master
//   adder_en/state/adder_in/done : adder control from the controller
//   result/res_valid/ovf         : captured product and its status
interface mul_seq_ctrl_if;
  logic        start;
  logic [15:0] a;
  logic [2:0]  b;
  logic        abort;
  logic [16:0] adder_out;
  logic        ready;
  logic        adder_en;
  logic [2:0]  state;
  logic [15:0] adder_in;
  logic        done;
  logic [16:0] result;
  logic        res_valid;
  logic        ovf;
  logic        err;

  modport master (
    output start, a, b, abort, adder_out,
    input  ready, adder_en, state, adder_in, done, result, res_valid, ovf, err
  );

  modport slave (
    input  start, a, b, abort, adder_out,
    output ready, adder_en, state, adder_in, done, result, res_valid, ovf, err
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequences an external 17-bit accumulator to form a*b by
// repeated addition (b in 0..6). One COMPUTE state per addition, then a
// DONE cycle that clears the adder while the product is captured.
// Ports:
//   clk           : clock, rising edge
//   rst           : asynchronous active-high reset
//   bus           : slave side of mul_seq_ctrl_if (request, adder, result)
//   o_adder_rst_n : active-low reset for the external adder
module mul_seq_ctrl (
  input  logic           clk,
  input  logic           rst,
  mul_seq_ctrl_if.slave  bus,
  output logic           o_adder_rst_n
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    C1    = 3'd1,
    C2    = 3'd2,
    C3    = 3'd3,
    C4    = 3'd4,
    C5    = 3'd5,
    C6    = 3'd6,
    DONE  = 3'd7
  } state_t;

  state_t      r_state;
  logic        r_ready;
  logic        r_en;
  logic [15:0] r_adder_in;
  logic        r_done;
  logic [16:0] r_result;
  logic        r_res_valid;
  logic        r_ovf;
  logic        r_err;
  logic [15:0] r_a;
  logic [2:0]  r_b;
  logic        r_abt;
  logic        w_carry;

  // Carry-out of the 17-bit accumulate this cycle would produce.
  function automatic logic carry17(input logic [16:0] acc, input logic [15:0] add);
    logic [17:0] s;
    s = {1'b0, acc} + {2'b00, add};
    return s[17];
  endfunction

  assign w_carry = carry17(bus.adder_out, r_adder_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ready     <= 1'b1;
      r_en        <= 1'b0;
      r_adder_in  <= '0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_res_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_abt       <= 1'b0;
    end else begin
      r_err       <= 1'b0;
      r_res_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          // abort is ignored here, so start+abort behaves as start alone
          if (bus.start) begin
            if (bus.b == 3'd7) begin
              r_err <= 1'b1;
            end else begin
              r_a        <= bus.a;
              r_b        <= bus.b;
              r_adder_in <= bus.a;
              r_ovf      <= 1'b0;
              r_abt      <= 1'b0;
              r_ready    <= 1'b0;
              if (bus.b == 3'd0) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= C1;
                r_en    <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          // An aborted operation still passes through DONE to clear the
          // adder, but its partial sum is never published.
          if (!r_abt) begin
            r_result    <= bus.adder_out;
            r_res_valid <= 1'b1;
          end
          r_state    <= IDLE;
          r_ready    <= 1'b1;
          r_done     <= 1'b0;
          r_adder_in <= '0;
        end
        default: begin
          if (bus.abort) begin
            r_abt   <= 1'b1;
            r_state <= DONE;
            r_en    <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            if (w_carry) r_ovf <= 1'b1;
            if (3'(r_state) < r_b) begin
              r_state <= state_t'(3'(r_state) + 3'd1);
            end else begin
              r_state <= DONE;
              r_en    <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.ready     = r_ready;
  // abort must suppress the addition in the very cycle it is seen
  assign bus.adder_en  = r_en & ~bus.abort;
  assign bus.state     = 3'(r_state);
  assign bus.adder_in  = r_adder_in;
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.res_valid = r_res_valid;
  assign bus.ovf       = r_ovf;
  assign bus.err       = r_err;
  assign o_adder_rst_n = ~rst;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
module tb_mul_seq_ctrl;
  logic clk;
  logic rst;
  logic w_adder_rst_n;
  logic [16:0] acc;
  int n_vec;
  int n_err;
  logic [16:0] m_result;
  logic        m_ovf;

  mul_seq_ctrl_if bus();

  mul_seq_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .o_adder_rst_n (w_adder_rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External accumulator: cleared by done, adds adder_in when enabled.
  always @(posedge clk or negedge w_adder_rst_n) begin
    if (!w_adder_rst_n)   acc <= '0;
    else if (bus.done)    acc <= '0;
    else if (bus.adder_en) acc <= acc + {1'b0, bus.adder_in};
  end
  assign bus.adder_out = acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic over(input int n, input logic [15:0] a);
    return (n * int'(a)) >= 131072;
  endfunction

  // One operation with abort in COMPUTE_abk (0 = none); reference is plain
  // arithmetic: product mod 2^17, overflow iff partial product reaches 2^17.
  task automatic op(input logic [15:0] a, input logic [2:0] b, input int abk, input bit pile);
    int nadd;
    bit abt;
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.abort = 1'($urandom_range(0, 1));
    #1;
    chk("accept_ready", bus.ready, 1);
    chk("accept_state", bus.state, 0);
    chk("idle_adder_en", bus.adder_en, 0);
    chk("idle_adder_in", bus.adder_in, 0);
    chk("idle_ovf_held", bus.ovf, m_ovf);
    abt = 0; nadd = 0;
    for (int k = 1; k <= int'(b); k++) begin
      @(negedge clk);
      bus.start = (pile && k == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.a = 16'($urandom); bus.b = 3'($urandom);
      bus.abort = (k == abk);
      #1;
      chk("compute_state", bus.state, k);
      chk("compute_adder_en", bus.adder_en, (k != abk));
      chk("compute_adder_in", bus.adder_in, a);
      chk("compute_done", bus.done, 0);
      chk("compute_ready", bus.ready, 0);
      chk("compute_err", bus.err, 0);
      chk("compute_ovf", bus.ovf, over(k - 1, a));
      if (k == abk) begin
        abt = 1;
        break;
      end
      nadd = k;
    end
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'($urandom_range(0, 1));
    #1;
    chk("done_state", bus.state, 7);
    chk("done_pulse", bus.done, 1);
    chk("done_adder_en", bus.adder_en, 0);
    chk("done_ready", bus.ready, 0);
    m_ovf = over(nadd, a);
    chk("done_ovf", bus.ovf, m_ovf);
    if (!abt) m_result = 17'((nadd * int'(a)) % 131072);
    @(negedge clk);
    bus.abort = 1'b0;
    #1;
    chk("post_ready", bus.ready, 1);
    chk("post_state", bus.state, 0);
    chk("post_done", bus.done, 0);
    chk("post_adder_in", bus.adder_in, 0);
    chk("post_res_valid", bus.res_valid, !abt);
    chk("post_result", bus.result, m_result);
    chk("post_ovf", bus.ovf, m_ovf);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_result = '0; m_ovf = 1'b0;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.abort = 1'b0;
    #2;
    chk("rst_state", bus.state, 0);
    chk("rst_ready", bus.ready, 1);
    chk("rst_result", bus.result, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_adder_rst_n", w_adder_rst_n, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Nominal multiply
    op(16'h1234, 3'd3, 0, 0);
    chk("nominal_result", bus.result, 17'h0369C);
    chk("nominal_ovf", bus.ovf, 0);

    // Zero multiplier
    op(16'hFFFF, 3'd0, 0, 0);
    chk("zero_result", bus.result, 0);

    // Overflow with wrapped result, flag held until the next start
    op(16'hFFFF, 3'd6, 0, 0);
    chk("ovf_result", bus.result, 17'h1FFFA);
    chk("ovf_flag", bus.ovf, 1);
    @(negedge clk); #1;
    chk("ovf_sticky", bus.ovf, 1);

    // Illegal multiplier
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'($urandom); bus.b = 3'd7;
    #1;
    chk("illegal_ready_before", bus.ready, 1);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk("illegal_err", bus.err, 1);
    chk("illegal_ready", bus.ready, 1);
    chk("illegal_state", bus.state, 0);
    chk("illegal_result", bus.result, m_result);
    chk("illegal_ovf", bus.ovf, 1);
    @(negedge clk); #1;
    chk("illegal_err_clear", bus.err, 0);

    // Busy start ignored
    op(16'h0005, 3'd4, 0, 1);
    chk("busy_result", bus.result, 17'h00014);

    // Abort leaves result untouched
    op(16'h0010, 3'd6, 2, 0);
    chk("abort_result", bus.result, 17'h00014);
    op(16'h0002, 3'd2, 0, 0);
    chk("after_abort_result", bus.result, 17'h00004);

    // Reset mid-operation
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h0123; bus.b = 3'd6;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #1;
    chk("pre_rst_state", bus.state, 4);
    rst = 1'b1;
    #1;
    chk("midrst_state", bus.state, 0);
    chk("midrst_ready", bus.ready, 1);
    chk("midrst_adder_en", bus.adder_en, 0);
    chk("midrst_adder_in", bus.adder_in, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_result", bus.result, 0);
    chk("midrst_res_valid", bus.res_valid, 0);
    chk("midrst_ovf", bus.ovf, 0);
    chk("midrst_err", bus.err, 0);
    m_result = '0; m_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("postrst_done", bus.done, 0);
      chk("postrst_res_valid", bus.res_valid, 0);
    end
    op(16'h0001, 3'd1, 0, 0);
    chk("postrst_result", bus.result, 1);

    // Randomized operations against the arithmetic reference
    for (int t = 0; t < 25; t++) begin
      logic [15:0] ra;
      logic [2:0]  rb;
      int          rk;
      ra = 16'($urandom);
      rb = 3'($urandom_range(0, 6));
      rk = 0;
      if (rb != 0 && $urandom_range(0, 3) == 0) rk = int'($urandom_range(1, int'(rb)));
      op(ra, rb, rk, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
